// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - turn-signal command encodings shared with the tail-light sequencer.
package tl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RIGHT = 2'b01,
        S_LEFT  = 2'b10,
        S_HAZ   = 2'b11
    } s_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HOLD  = 2'b01,
        ST_ARMED = 2'b10
    } cmd_state_t;

    // Hazard, or both stalks at once, outranks a single direction.
    function automatic s_code_t decode_req(input logic left, input logic right, input logic haz);
        if (haz || (left && right)) return S_HAZ;
        if (left)                   return S_LEFT;
        if (right)                  return S_RIGHT;
        return S_IDLE;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - two-flop synchronizer followed by a consecutive-cycle debounce counter.
module sw_debounce #(
    parameter int unsigned DEB_CNT = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic in,
    output logic out
);

    localparam int unsigned CW = (DEB_CNT > 2) ? $clog2(DEB_CNT) : 1;

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    // cnt holds the number of consecutive disagreeing cycles already seen; it never exceeds DEB_CNT-1.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            out  <= 1'b0;
            cnt  <= '0;
        end else begin
            meta <= in;
            sync <= meta;
            if (sync == out) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CNT - 1)) begin
                out <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/turn_cmd_cond.sv
// rtl/turn_cmd_cond.sv - debounces the stalk/hazard switches and issues held S commands with a Chg strobe.
module turn_cmd_cond
    import tl_pkg::*;
#(
    parameter int unsigned DEB_CNT  = 4,
    parameter int unsigned MIN_HOLD = 12
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       LeftSw,
    input  logic       RightSw,
    input  logic       HazSw,
    output logic [1:0] S,
    output logic       Chg
);

    localparam int unsigned HW = $clog2(MIN_HOLD + 1);

    logic          left_db;
    logic          right_db;
    logic          haz_db;
    s_code_t       req;
    cmd_state_t    state;
    logic [HW-1:0] hold;

    sw_debounce #(.DEB_CNT(DEB_CNT)) u_left  (.Clk(Clk), .Rst(Rst), .in(LeftSw),  .out(left_db));
    sw_debounce #(.DEB_CNT(DEB_CNT)) u_right (.Clk(Clk), .Rst(Rst), .in(RightSw), .out(right_db));
    sw_debounce #(.DEB_CNT(DEB_CNT)) u_haz   (.Clk(Clk), .Rst(Rst), .in(HazSw),   .out(haz_db));

    assign req = decode_req(left_db, right_db, haz_db);

    // HOLD ignores the request entirely; whatever is decoded on the first ARMED cycle wins.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= ST_IDLE;
            S     <= S_IDLE;
            Chg   <= 1'b0;
            hold  <= '0;
        end else begin
            Chg <= 1'b0;
            case (state)
                ST_IDLE, ST_ARMED: begin
                    if (req != S) begin
                        S     <= req;
                        Chg   <= 1'b1;
                        hold  <= HW'(MIN_HOLD - 1);
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold == '0) state <= ST_ARMED;
                    else            hold  <= hold - HW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
